// File: rtl/uart_rx_ctrl.sv
// Sequencing and configuration controller for uart_rx: frame tracking with a
// watchdog, shadowed frame configuration, and a small receive FIFO with status.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2,
    parameter int WDOG_CYC   = 208
) (
    input  logic              rx_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_length,
    input  logic              cfg_parity_type,
    input  logic              cfg_parity_en,
    input  logic              cfg_stop2,
    input  logic              rx_line,
    output logic              rx_start,
    output logic [3:0]        length,
    output logic              parity_type,
    output logic              parity_en,
    output logic              stop2,
    input  logic [7:0]        rx_out,
    input  logic              rx_done,
    input  logic              rx_error,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun,
    output logic [7:0]        err_count,
    output logic              wdog_abort,
    output logic              cfg_pending,
    output logic              cfg_reject,
    input  logic              clr_status
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ARMED,
        ST_BUSY
    } state_t;

    localparam int                WDOG_W    = $clog2(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(FIFO_DEPTH);

    state_t            state;
    logic              sticky_err;
    logic [WDOG_W-1:0] wdog;

    logic [3:0] sh_length;
    logic       sh_parity_type;
    logic       sh_parity_en;
    logic       sh_stop2;

    logic [8:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic start_frame;
    logic apply_cfg;
    logic cfg_legal;
    logic push;
    logic push_err;
    logic wdog_hit;
    logic pop;
    logic full;
    logic do_push;
    logic drop;

    assign start_frame = (state == ST_ARMED) && enable && !rx_line;
    // The receiver only sees new settings between frames, never on the start edge.
    assign apply_cfg   = (state != ST_BUSY) && !start_frame;
    assign cfg_legal   = (cfg_length >= 4'd5) && (cfg_length <= 4'd8);
    assign push        = (state == ST_BUSY) && rx_done;
    assign push_err    = sticky_err | rx_error;
    assign wdog_hit    = (state == ST_BUSY) && !rx_done && (wdog == WDOG_LAST);

    assign rd_valid    = (count != '0);
    assign full        = (count == DEPTH_L);
    assign pop         = rd_valid && rd_ready;
    assign do_push     = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign fifo_count  = count;
    assign rd_data     = rd_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign rd_err      = rd_valid ? mem[rd_ptr][8]   : 1'b0;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_DISABLED;
            rx_start   <= 1'b0;
            sticky_err <= 1'b0;
            wdog       <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= 1'b0;
            case (state)
                ST_DISABLED: begin
                    if (enable) begin
                        state    <= ST_ARMED;
                        rx_start <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!enable) begin
                        state    <= ST_DISABLED;
                        rx_start <= 1'b0;
                    end else if (!rx_line) begin
                        state      <= ST_BUSY;
                        sticky_err <= 1'b0;
                        wdog       <= '0;
                    end
                end
                ST_BUSY: begin
                    sticky_err <= sticky_err | rx_error;
                    wdog       <= wdog + 1'b1;
                    if (rx_done || wdog_hit) begin
                        state      <= enable ? ST_ARMED : ST_DISABLED;
                        rx_start   <= enable;
                        wdog_abort <= !rx_done;
                    end
                end
                default: begin
                    state    <= ST_DISABLED;
                    rx_start <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            length         <= 4'd8;
            parity_type    <= 1'b0;
            parity_en      <= 1'b0;
            stop2          <= 1'b0;
            sh_length      <= 4'd8;
            sh_parity_type <= 1'b0;
            sh_parity_en   <= 1'b0;
            sh_stop2       <= 1'b0;
            cfg_pending    <= 1'b0;
            cfg_reject     <= 1'b0;
        end else begin
            cfg_reject <= cfg_wr && !cfg_legal;
            if (apply_cfg) begin
                length      <= sh_length;
                parity_type <= sh_parity_type;
                parity_en   <= sh_parity_en;
                stop2       <= sh_stop2;
                cfg_pending <= 1'b0;
            end
            // NOTE: this later assignment overrides the clear above, so a write
            // landing on an apply slot stays pending for the next slot.
            if (cfg_wr && cfg_legal) begin
                sh_length      <= cfg_length;
                sh_parity_type <= cfg_parity_type;
                sh_parity_en   <= cfg_parity_en;
                sh_stop2       <= cfg_stop2;
                cfg_pending    <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; the read port is gated by rd_valid, so stale
    // contents are never visible.
    always_ff @(posedge rx_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_err, rx_out};
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Events take priority over a simultaneous clear.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (push && push_err) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (clr_status) begin
                err_count <= 8'h00;
            end
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences and configures the uart_rx receiver. It holds the frame configuration in shadow registers and applies it only between frames. It drives rx_start, tracks each frame from start edge to rx_done, and latches the receiver's transient rx_error into a per-frame sticky flag. Received bytes go into a small FIFO with a host valid/ready read port, plus overrun and error-count status.

Parameters:
FIFO_DEPTH, 4, entries in receive FIFO (power of 2, >=2)
ADDR_W, 2, log2(FIFO_DEPTH)
WDOG_CYC, 208, max rx_clk cycles in BUSY before the frame is abandoned (>= 13 bits * 16)

Ports:
rx_clk  in  1  clock (same clock as uart_rx)
rst  in  1  asynchronous active-high reset
enable  in  1  1 = receive frames
cfg_wr  in  1  pulse: load cfg_* into shadow
cfg_length  in  4  data bits, legal 5..8
cfg_parity_type  in  1  parity type for receiver
cfg_parity_en  in  1  parity enable
cfg_stop2  in  1  two stop bits
rx_line  in  1  serial line, same net as uart_rx rx
rx_start  out  1  to uart_rx
length  out  4  to uart_rx
parity_type  out  1  to uart_rx
parity_en  out  1  to uart_rx
stop2  out  1  to uart_rx
rx_out  in  8  from uart_rx
rx_done  in  1  from uart_rx
rx_error  in  1  from uart_rx, transient
rd_valid  out  1  FIFO non-empty
rd_data  out  8  head byte
rd_err  out  1  head entry error flag
rd_ready  in  1  host pop
fifo_count  out  ADDR_W+1  occupancy
overrun  out  1  sticky: frame dropped while FIFO full
err_count  out  8  frames with error, saturating
wdog_abort  out  1  1-cycle pulse on watchdog abandon
cfg_pending  out  1  shadow config not yet applied
cfg_reject  out  1  1-cycle pulse: cfg_wr with illegal length
clr_status  in  1  pulse: clear overrun and err_count

Behaviour:
- Reset (async): state DISABLED; rx_start=0; length=8, parity_type=0, parity_en=0, stop2=0; shadow config identical to these; FIFO empty; rd_valid=0, rd_data=0, rd_err=0; fifo_count=0; overrun=0, err_count=0; wdog_abort=0, cfg_pending=0, cfg_reject=0; sticky error=0, watchdog=0. Reset mid-frame discards the frame.
- FSM states:
  - DISABLED: rx_start=0. When enable=1, go to ARMED.
  - ARMED: rx_start=1. When enable=0, go to DISABLED. When rx_line=0, go to BUSY; clear sticky error and watchdog.
  - BUSY: rx_start=1. Sticky error |= rx_error each cycle. Watchdog increments each cycle.
    - On rx_done=1: push {sticky|rx_error, rx_out} and go to ARMED (DISABLED if enable=0).
    - On watchdog reaching WDOG_CYC-1 with no rx_done: no push, wdog_abort=1 for 1 cycle, go to ARMED/DISABLED.
    - enable=0 in BUSY does not cut the frame short.
- A false start (uart_rx returns to idle) is caught by the watchdog. An rx_done at any time in BUSY is accepted.
- Config:
  - cfg_wr with cfg_length in 5..8 loads the shadow and sets cfg_pending=1.
  - cfg_wr with any other length leaves the shadow unchanged and pulses cfg_reject next cycle.
  - The shadow copies to the receiver outputs on any clock where state != BUSY and there is no ARMED->BUSY transition that cycle; cfg_pending then clears.
  - cfg_wr in the same cycle as an apply: the new values win and cfg_pending stays 1 until the next apply slot.
- FIFO: registered storage, 1-cycle latency from push to rd_valid. rd_data/rd_err show the head entry while rd_valid=1; pop when rd_valid & rd_ready.
  - Push when full: entry dropped, overrun=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- err_count increments on each accepted rx_done whose error flag is 1, including dropped frames, and saturates at 255.
- clr_status clears overrun and err_count. A simultaneous increment or overrun event wins over the clear.

Test Plan:
- Reset, enable=1, default config, send 8N1 byte 0xA5 at 16 clocks/bit -> rx_start=1; one FIFO entry rd_data=0xA5, rd_err=0; fifo_count=1; err_count=0.
- cfg_wr length=7, parity_en=1, parity_type=1 issued mid-frame -> length stays 8 until rx_done, then becomes 7 the next cycle; cfg_pending is 1 for that interval. cfg_wr length=4 -> cfg_reject pulse, shadow unchanged.
- Frame with a bad stop bit (rx_error pulses at count 7, then clears) -> entry rd_err=1 and err_count=1, although rx_error=0 at rx_done.
- Five frames 0x01..0x05 with rd_ready=0 -> fifo_count=4, overrun=1; pop order 0x01..0x04. Then push+pop in the same cycle at full -> count stays 4.
- Single low glitch of 3 cycles on rx_line -> no push, wdog_abort pulse exactly WDOG_CYC cycles after entering BUSY, back to ARMED.
- Assert rst for 1 cycle mid-frame with 2 entries queued -> all outputs at reset values immediately (asynchronous), fifo_count=0.
